axi_lite_reg_router: RTL and testbench

//  Sits behind axi_lite_slave's simple user register interface and shares it between NUM_SLOTS register clients.

---
 rtl/axi_lite_reg_router.sv | 148 ++++++++++++++
 tb/tb_axi_lite_reg_router.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_reg_router.sv
// Shares one simple register port between NUM_SLOTS clients: decodes the slot, strobes it,
// waits for its ack (or a timeout) and returns a single response strobe to the slave.
module axi_lite_reg_router #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLOTS      = 4,
  parameter int SLOT_ADDR_BITS = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_reg_in_rdy,
  output logic                            o_reg_in_ack_stb,
  input  logic [ADDR_WIDTH-1:0]           i_reg_address,
  input  logic [DATA_WIDTH-1:0]           i_reg_in_data,
  input  logic                            i_reg_out_req,
  output logic                            o_reg_out_rdy_stb,
  output logic [DATA_WIDTH-1:0]           o_reg_out_data,
  output logic                            o_reg_invalid_addr,
  output logic [NUM_SLOTS-1:0]            o_slot_wr_stb,
  output logic [NUM_SLOTS-1:0]            o_slot_rd_stb,
  output logic [SLOT_ADDR_BITS-1:0]       o_slot_addr,
  output logic [DATA_WIDTH-1:0]           o_slot_wdata,
  input  logic [NUM_SLOTS-1:0]            i_slot_ack,
  input  logic [NUM_SLOTS*DATA_WIDTH-1:0] i_slot_rdata
);
  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, RESPOND, RELEASE} state_t;

  state_t                    state, state_nx;
  logic                      is_wr, is_wr_nx;
  logic [IDX_W-1:0]          idx, idx_nx;
  logic [CNT_W-1:0]          cnt, cnt_nx;
  logic [NUM_SLOTS-1:0]      wr_stb_nx, rd_stb_nx;
  logic [SLOT_ADDR_BITS-1:0] addr_nx;
  logic [DATA_WIDTH-1:0]     wdata_nx, out_data_nx;
  logic                      ack_stb_nx, rdy_stb_nx, invalid_nx;

  logic [IDX_W-1:0]          req_idx;
  logic                      req_bad;
  logic                      sel_ack;
  logic [DATA_WIDTH-1:0]     sel_rdata;
  logic                      resp_go, resp_err;
  logic [DATA_WIDTH-1:0]     resp_data;

  assign req_idx   = i_reg_address[SLOT_ADDR_BITS +: IDX_W];
  assign req_bad   = (32'(req_idx) >= 32'(NUM_SLOTS)) ||
                     (|(i_reg_address >> (SLOT_ADDR_BITS + IDX_W)));
  assign sel_ack   = i_slot_ack[idx];
  assign sel_rdata = i_slot_rdata[int'(idx) * DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_nx    = state;
    is_wr_nx    = is_wr;
    idx_nx      = idx;
    cnt_nx      = cnt;
    wr_stb_nx   = '0;
    rd_stb_nx   = '0;
    addr_nx     = o_slot_addr;
    wdata_nx    = o_slot_wdata;
    ack_stb_nx  = 1'b0;
    rdy_stb_nx  = 1'b0;
    invalid_nx  = o_reg_invalid_addr;
    out_data_nx = o_reg_out_data;
    resp_go     = 1'b0;
    resp_err    = 1'b0;
    resp_data   = '0;

    case (state)
      IDLE: begin
        if (i_reg_in_rdy || i_reg_out_req) begin
          is_wr_nx   = i_reg_in_rdy;
          idx_nx     = req_idx;
          addr_nx    = i_reg_address[SLOT_ADDR_BITS-1:0];
          wdata_nx   = i_reg_in_data;
          invalid_nx = 1'b0;
          cnt_nx     = '0;
          if (req_bad) begin
            resp_go  = 1'b1;
            resp_err = 1'b1;
          end else begin
            state_nx = WAIT_ACK;
            if (i_reg_in_rdy) wr_stb_nx = NUM_SLOTS'(1) << req_idx;
            else              rd_stb_nx = NUM_SLOTS'(1) << req_idx;
          end
        end
      end
      WAIT_ACK: begin
        cnt_nx = cnt + 1'b1;
        if (sel_ack) begin
          resp_go   = 1'b1;
          resp_data = sel_rdata;
        end else if (cnt == CNT_LAST) begin
          resp_go  = 1'b1;
          resp_err = 1'b1;
        end
      end
      RESPOND: state_nx = RELEASE;
      RELEASE: if (!i_reg_in_rdy && !i_reg_out_req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Response strobes are registered, so they are loaded on the edge that enters RESPOND.
    if (resp_go) begin
      state_nx   = RESPOND;
      invalid_nx = resp_err;
      if (is_wr_nx) begin
        ack_stb_nx = 1'b1;
      end else begin
        rdy_stb_nx  = 1'b1;
        out_data_nx = resp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      is_wr              <= 1'b0;
      idx                <= '0;
      cnt                <= '0;
      o_slot_wr_stb      <= '0;
      o_slot_rd_stb      <= '0;
      o_slot_addr        <= '0;
      o_slot_wdata       <= '0;
      o_reg_in_ack_stb   <= 1'b0;
      o_reg_out_rdy_stb  <= 1'b0;
      o_reg_invalid_addr <= 1'b0;
      o_reg_out_data     <= '0;
    end else begin
      state              <= state_nx;
      is_wr              <= is_wr_nx;
      idx                <= idx_nx;
      cnt                <= cnt_nx;
      o_slot_wr_stb      <= wr_stb_nx;
      o_slot_rd_stb      <= rd_stb_nx;
      o_slot_addr        <= addr_nx;
      o_slot_wdata       <= wdata_nx;
      o_reg_in_ack_stb   <= ack_stb_nx;
      o_reg_out_rdy_stb  <= rdy_stb_nx;
      o_reg_invalid_addr <= invalid_nx;
      o_reg_out_data     <= out_data_nx;
    end
  end
endmodule

// File: tb/tb_axi_lite_reg_router.sv
// Directed bench: a transaction-level model predicts strobe/response cycles and data, checked every cycle.
module tb_axi_lite_reg_router;
  localparam int NS  = 4;
  localparam int SAB = 8;
  localparam int T   = 256;
  localparam logic [127:0] DEF_RDATA = 128'h3333_3333_2222_2222_1111_1111_0F0F_0F0F;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_reg_in_rdy, i_reg_out_req;
  logic [31:0]  i_reg_address, i_reg_in_data;
  logic         o_reg_in_ack_stb, o_reg_out_rdy_stb, o_reg_invalid_addr;
  logic [31:0]  o_reg_out_data, o_slot_wdata;
  logic [3:0]   o_slot_wr_stb, o_slot_rd_stb, i_slot_ack;
  logic [7:0]   o_slot_addr;
  logic [127:0] i_slot_rdata;

  axi_lite_reg_router dut (
    .clk(clk), .rst(rst),
    .i_reg_in_rdy(i_reg_in_rdy), .o_reg_in_ack_stb(o_reg_in_ack_stb),
    .i_reg_address(i_reg_address), .i_reg_in_data(i_reg_in_data),
    .i_reg_out_req(i_reg_out_req), .o_reg_out_rdy_stb(o_reg_out_rdy_stb),
    .o_reg_out_data(o_reg_out_data), .o_reg_invalid_addr(o_reg_invalid_addr),
    .o_slot_wr_stb(o_slot_wr_stb), .o_slot_rd_stb(o_slot_rd_stb),
    .o_slot_addr(o_slot_addr), .o_slot_wdata(o_slot_wdata),
    .i_slot_ack(i_slot_ack), .i_slot_rdata(i_slot_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [3:0] wr; logic [3:0] rd; logic [7:0] a; logic [31:0] d; } stb_t;
  typedef struct { int cyc; bit wr; logic [31:0] d; bit inv; } rsp_t;

  stb_t        sq[$];
  rsp_t        rq[$];
  logic [31:0] last_rdata = '0;
  int          checks = 0, failures = 0, cyc = 0, n = 0;
  int          obs_stb_cyc, obs_resp_cyc;
  logic [3:0]  obs_wr, obs_rd;
  logic [7:0]  obs_addr;
  logic [31:0] obs_data;
  logic        obs_inv;
  stb_t        s5;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model, sampled at the falling edge.
  task automatic compare_cycle();
    logic [3:0] ew, er;
    logic       eack, erdy;
    ew = '0; er = '0; eack = 1'b0; erdy = 1'b0;
    if (!rst) begin
      sq.delete();
      rq.delete();
      last_rdata = '0;
      chk("rst_slot_addr", o_slot_addr, 0);
      chk("rst_slot_wdata", o_slot_wdata, 0);
      chk("rst_invalid", o_reg_invalid_addr, 0);
    end else begin
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        ew = sq[0].wr;
        er = sq[0].rd;
        chk("slot_addr", o_slot_addr, sq[0].a);
        chk("slot_wdata", o_slot_wdata, sq[0].d);
        void'(sq.pop_front());
      end
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        if (rq[0].wr) eack = 1'b1;
        else begin
          erdy = 1'b1;
          last_rdata = rq[0].d;
        end
        chk("invalid_flag", o_reg_invalid_addr, rq[0].inv);
        void'(rq.pop_front());
      end
    end
    chk("slot_wr_stb", o_slot_wr_stb, ew);
    chk("slot_rd_stb", o_slot_rd_stb, er);
    chk("reg_in_ack_stb", o_reg_in_ack_stb, eack);
    chk("reg_out_rdy_stb", o_reg_out_rdy_stb, erdy);
    chk("reg_out_data", o_reg_out_data, last_rdata);
    if (o_reg_in_ack_stb || o_reg_out_rdy_stb) begin
      obs_resp_cyc = cyc;
      obs_data     = o_reg_out_data;
      obs_inv      = o_reg_invalid_addr;
    end
    if (|o_slot_wr_stb || |o_slot_rd_stb) begin
      obs_stb_cyc = cyc;
      obs_wr      = o_slot_wr_stb;
      obs_rd      = o_slot_rd_stb;
      obs_addr    = o_slot_addr;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // dly: cycles after the slot strobe that the slot acks (-1 = never).
  task automatic do_txn(input bit wr, input bit both, input logic [31:0] a, input logic [31:0] d,
                        input int dly, input logic [31:0] ackd, input int stray, input bit late,
                        input int hold, output int req_cyc);
    bit   valid, is_w, acked;
    int   slot, resp;
    stb_t s;
    rsp_t r;
    req_cyc      = cyc;
    valid        = (a < 32'(NS * (1 << SAB)));
    slot         = int'(a / (1 << SAB));
    is_w         = wr || both;
    acked        = valid && dly >= 0 && dly < T;
    obs_stb_cyc  = -1;
    obs_resp_cyc = -1;
    i_reg_address = a;
    i_reg_in_data = d;
    i_reg_in_rdy  = is_w;
    i_reg_out_req = !wr || both;
    if (valid) begin
      s.cyc = req_cyc + 1;
      s.wr  = is_w ? 4'(1 << slot) : 4'b0;
      s.rd  = is_w ? 4'b0 : 4'(1 << slot);
      s.a   = 8'(a % (1 << SAB));
      s.d   = d;
      sq.push_back(s);
      resp  = acked ? req_cyc + 2 + dly : req_cyc + 1 + T;
    end else begin
      resp  = req_cyc + 1;
    end
    r.cyc = resp;
    r.wr  = is_w;
    r.d   = acked ? ackd : 32'h0;
    r.inv = !acked;
    rq.push_back(r);
    do begin
      i_slot_ack   = '0;
      i_slot_rdata = DEF_RDATA;
      if (acked && cyc == req_cyc + 1 + dly) begin
        i_slot_ack[slot] = 1'b1;
        i_slot_rdata[slot*32 +: 32] = ackd;
      end
      if (valid && stray >= 0 && cyc == req_cyc + 1 + stray) i_slot_ack[0] = 1'b1;
      if (valid && late && (cyc == resp || cyc == resp + 1)) i_slot_ack[slot] = 1'b1;
      step();
    end while (cyc < resp + hold);
    i_reg_in_rdy  = 1'b0;
    i_reg_out_req = 1'b0;
    i_slot_ack    = '0;
    i_slot_rdata  = DEF_RDATA;
    step();
    step();
  endtask

  initial begin
    rst = 1'b0;
    i_reg_in_rdy = 1'b0; i_reg_out_req = 1'b0;
    i_reg_address = '0; i_reg_in_data = '0;
    i_slot_ack = '0; i_slot_rdata = DEF_RDATA;
    @(posedge clk);
    #1;
    repeat (3) step();
    chk("reset_strobes", {o_reg_in_ack_stb, o_reg_out_rdy_stb, o_slot_wr_stb, o_slot_rd_stb}, 0);
    rst = 1'b1;
    step();

    // Write to slot 2, acked 3 cycles after the strobe.
    do_txn(1, 0, 32'h0000_0210, 32'hA5A5_0001, 3, 32'h0, -1, 0, 1, n);
    chk("t1_stb_lat", obs_stb_cyc - n, 1);
    chk("t1_wr_stb", obs_wr, 4'b0100);
    chk("t1_slot_addr", obs_addr, 8'h10);
    chk("t1_ack_lat", obs_resp_cyc - n, 5);
    chk("t1_invalid", obs_inv, 0);

    // Read slot 1, acked on the strobe cycle; request held three extra cycles.
    do_txn(0, 0, 32'h0000_0104, 32'h0, 0, 32'hDEAD_BEEF, -1, 0, 3, n);
    chk("t2_rd_stb", obs_rd, 4'b0010);
    chk("t2_single_strobe", obs_stb_cyc - n, 1);
    chk("t2_lat", obs_resp_cyc - n, 2);
    chk("t2_data", obs_data, 32'hDEAD_BEEF);
    chk("t2_invalid", obs_inv, 0);

    // Write and read requested together: the write wins.
    do_txn(1, 1, 32'h0000_0008, 32'h0000_0077, 1, 32'h0, -1, 0, 1, n);
    chk("prio_wr_stb", obs_wr, 4'b0001);
    chk("prio_rd_stb", obs_rd, 4'b0000);
    chk("prio_lat", obs_resp_cyc - n, 3);

    // Invalid addresses: slot index out of range, then an upper address bit set.
    do_txn(0, 0, 32'h0000_0500, 32'h0, 0, 32'h9999, -1, 0, 1, n);
    chk("t3a_no_stb", obs_stb_cyc + 1, 0);
    chk("t3a_lat", obs_resp_cyc - n, 1);
    chk("t3a_invalid", obs_inv, 1);
    chk("t3a_data", obs_data, 0);
    do_txn(0, 0, 32'h0001_0000, 32'h0, 0, 32'h9999, -1, 0, 1, n);
    chk("t3b_no_stb", obs_stb_cyc + 1, 0);
    chk("t3b_lat", obs_resp_cyc - n, 1);
    chk("t3b_invalid", obs_inv, 1);

    // Read timeout on slot 3.
    do_txn(0, 0, 32'h0000_0300, 32'h0, -1, 32'h0, -1, 0, 1, n);
    chk("rto_lat", obs_resp_cyc - n, 257);
    chk("rto_invalid", obs_inv, 1);
    chk("rto_data", obs_data, 0);

    // Write timeout on slot 3 with a stray slot-0 ack inside and late slot-3 acks after.
    do_txn(1, 0, 32'h0000_030C, 32'h0BAD_F00D, -1, 32'h0, 10, 1, 2, n);
    chk("t4_lat", obs_resp_cyc - n, 257);
    chk("t4_invalid", obs_inv, 1);

    // Ack on the very last cycle before timeout is still accepted.
    do_txn(0, 0, 32'h0000_0208, 32'h0, T - 1, 32'h1234_5678, -1, 0, 1, n);
    chk("edge_lat", obs_resp_cyc - n, 257);
    chk("edge_data", obs_data, 32'h1234_5678);
    chk("edge_invalid", obs_inv, 0);

    // Reset in the middle of a write to slot 1 aborts it.
    n = cyc;
    i_reg_address = 32'h0000_01A4;
    i_reg_in_data = 32'h5555_AAAA;
    i_reg_in_rdy  = 1'b1;
    s5.cyc = n + 1; s5.wr = 4'b0010; s5.rd = 4'b0000; s5.a = 8'hA4; s5.d = 32'h5555_AAAA;
    sq.push_back(s5);
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("t5_ack_stb", o_reg_in_ack_stb, 0);
    chk("t5_slot_addr", o_slot_addr, 0);
    chk("t5_slot_wdata", o_slot_wdata, 0);
    chk("t5_out_data", o_reg_out_data, 0);
    i_reg_in_rdy = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    repeat (2) step();
    do_txn(1, 0, 32'h0000_0304, 32'hCAFE_0005, 1, 32'h0, -1, 0, 1, n);
    chk("t5_post_wr_stb", obs_wr, 4'b1000);
    chk("t5_post_lat", obs_resp_cyc - n, 3);
    chk("t5_post_invalid", obs_inv, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
